traffic_sequencer: RTL and testbench
====================================

TRAFFIC_SEQUENCER -- requirements
Module: traffic_sequencer

Interface
REQ-001 SHALL have the following ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  synchronous, active-low reset, sampled on rising clk.
- tick  in  1  one-cycle timebase strobe (1 Hz equivalent); timing advances only when high.
- ped_req  in  1  pedestrian button, level or pulse, sampled every clk.
- main_light  out  3  one-hot {red, yellow, green} for the main road.
- side_light  out  3  one-hot {red, yellow, green} for the side road.
- walk  out  1  pedestrian walk indication.
- ped_pending  out  1  latched, not-yet-served pedestrian request.
- cycle_cnt  out  6  ticks elapsed since the start of the current MAIN_GREEN; 0 at phase entry.

Function
REQ-002 SHALL implement an FSM with eight states in order: MAIN_GREEN(15), MAIN_YELLOW(2), ALL_RED_1(2), PED_WALK(6), ALL_RED_2(2), SIDE_GREEN(8), SIDE_YELLOW(2), ALL_RED_3(1). Parenthesised values are durations in ticks.
REQ-003 SHALL load the phase timer with duration-1 on phase entry and decrement it on each tick.
REQ-004 SHALL leave a phase on the clk edge where tick=1 and timer=0; the next state and new timer value are visible on that same edge.
REQ-005 SHALL go from ALL_RED_1 to PED_WALK if ped_pending=1 at the exit edge, otherwise to SIDE_GREEN.
REQ-006 SHALL always go from PED_WALK to ALL_RED_2, and from ALL_RED_2 to SIDE_GREEN.
REQ-007 SHALL go from ALL_RED_3 to MAIN_GREEN.
REQ-008 SHALL set ped_pending on any clk with ped_req=1, except while the state is PED_WALK.
REQ-009 SHALL clear ped_pending on the edge entering PED_WALK; clear has priority over a simultaneous set.
REQ-010 SHALL decode lights combinationally from the state register:
- main green/yellow only in MAIN_GREEN/MAIN_YELLOW; main red otherwise.
- side green/yellow only in SIDE_GREEN/SIDE_YELLOW; side red otherwise.
- walk=1 only in PED_WALK.
REQ-011 SHALL never drive green or yellow on both roads at once, and never drive walk while either road is non-red.
REQ-012 SHALL make cycle_cnt increment on each tick and reset to 0 on entry to MAIN_GREEN. Full cycle is 30 ticks without walk (cycle_cnt 0..29) and 38 ticks with walk (0..37); no wrap occurs within a cycle.
REQ-013 SHALL hold all state, timer and cycle_cnt when tick=0; ped_req sampling continues regardless of tick.
REQ-014 SHALL treat ped_req held high across PED_WALK as ignored, and set ped_pending again on the first clk after PED_WALK exits if still high.

Reset
REQ-015 SHALL on rst_n=0 set: state=MAIN_GREEN, timer=14, cycle_cnt=0, ped_pending=0. Outputs are then main_light=001, side_light=100, walk=0.
REQ-016 SHALL let reset override tick and ped_req in the same cycle.
REQ-017 SHALL make reset mid-phase, including PED_WALK, abandon the phase immediately, with no residual pending request.

Structure
REQ-018 SHALL place in the shared package:
- the state enum;
- phase duration constants;
- light encoding constants RED=3'b100, YEL=3'b010, GRN=3'b001.
REQ-019 SHALL use one sub-module, phase_timer: 6-bit loadable down-counter with ports clk, rst_n, load, load_val, tick, and expiry output done = (count==0) & tick.

Verification
REQ-020 SHALL cover: reset, then tick every clk, no ped_req -> MAIN_GREEN 15 clks, MAIN_YELLOW 2, ALL_RED_1 2, SIDE_GREEN 8, SIDE_YELLOW 2, ALL_RED_3 1, back to MAIN_GREEN at clk 30; walk never 1.
REQ-021 SHALL cover: ped_req pulse at cycle_cnt=3 -> ped_pending=1 next clk; PED_WALK entered at cycle_cnt=19 with walk=1 for 6 ticks; ped_pending=0 from PED_WALK entry; cycle length 38.
REQ-022 SHALL cover: ped_req held high through the whole cycle -> ped_pending=0 during PED_WALK and 1 again on the first clk of ALL_RED_2.
REQ-023 SHALL cover: tick asserted every 4th clk -> every phase lasts exactly 4x its tick count in clks; outputs stable between ticks.
REQ-024 SHALL cover: rst_n low for 1 clk during PED_WALK at timer=2 -> next clk shows main_light=001, walk=0, ped_pending=0, cycle_cnt=0.
REQ-025 SHALL cover: assertion across all runs that main and side are never simultaneously non-red, and walk=1 implies both are red.

Source files
------------

// File: rtl/traffic_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : traffic_sequencer_pkg
// Brief    : Shared phase enum, phase durations and light encodings.
// Revision : 1.0 - initial release
// ============================================================================
package traffic_sequencer_pkg;

  typedef enum logic [2:0] {
    MAIN_GREEN  = 3'd0,
    MAIN_YELLOW = 3'd1,
    ALL_RED_1   = 3'd2,
    PED_WALK    = 3'd3,
    ALL_RED_2   = 3'd4,
    SIDE_GREEN  = 3'd5,
    SIDE_YELLOW = 3'd6,
    ALL_RED_3   = 3'd7
  } state_e;

  localparam logic [5:0] MAIN_GREEN_TICKS  = 6'd15;
  localparam logic [5:0] MAIN_YELLOW_TICKS = 6'd2;
  localparam logic [5:0] ALL_RED_1_TICKS   = 6'd2;
  localparam logic [5:0] PED_WALK_TICKS    = 6'd6;
  localparam logic [5:0] ALL_RED_2_TICKS   = 6'd2;
  localparam logic [5:0] SIDE_GREEN_TICKS  = 6'd8;
  localparam logic [5:0] SIDE_YELLOW_TICKS = 6'd2;
  localparam logic [5:0] ALL_RED_3_TICKS   = 6'd1;

  localparam logic [2:0] RED = 3'b100;
  localparam logic [2:0] YEL = 3'b010;
  localparam logic [2:0] GRN = 3'b001;

  function automatic logic [5:0] phase_ticks(input state_e s);
    logic [5:0] t;
    case (s)
      MAIN_GREEN:  t = MAIN_GREEN_TICKS;
      MAIN_YELLOW: t = MAIN_YELLOW_TICKS;
      ALL_RED_1:   t = ALL_RED_1_TICKS;
      PED_WALK:    t = PED_WALK_TICKS;
      ALL_RED_2:   t = ALL_RED_2_TICKS;
      SIDE_GREEN:  t = SIDE_GREEN_TICKS;
      SIDE_YELLOW: t = SIDE_YELLOW_TICKS;
      ALL_RED_3:   t = ALL_RED_3_TICKS;
      default:     t = ALL_RED_3_TICKS;
    endcase
    return t;
  endfunction

endpackage
`default_nettype wire

// File: rtl/traffic_sequencer_phase_timer.sv
`default_nettype none
// ============================================================================
// Module   : phase_timer
// Brief    : 6-bit loadable down-counter; done pulses on a tick at count 0.
// Revision : 1.0 - initial release
// ============================================================================
module phase_timer #(
  parameter logic [5:0] RESET_VAL = 6'd0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [5:0] load_val,
  input  logic       tick,
  output logic       done
);

  logic [5:0] count_q;
  logic [5:0] count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (tick && (count_q != 6'd0)) begin
      count_d = count_q - 6'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= RESET_VAL;
    end else begin
      count_q <= count_d;
    end
  end

  assign done = (count_q == 6'd0) & tick;

endmodule
`default_nettype wire

// File: rtl/traffic_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : traffic_sequencer
// Brief    : Two-road traffic light sequencer with latched pedestrian phase.
// Revision : 1.0 - initial release
// ============================================================================
module traffic_sequencer
  import traffic_sequencer_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick,
  input  logic       ped_req,
  output logic [2:0] main_light,
  output logic [2:0] side_light,
  output logic       walk,
  output logic       ped_pending,
  output logic [5:0] cycle_cnt
);

  state_e     state_q, state_d;
  logic       ped_pending_q, ped_pending_d;
  logic [5:0] cycle_cnt_q, cycle_cnt_d;
  logic       timer_done;
  logic [5:0] timer_load_val;

  // The timer reloads on the exit edge with the duration of the phase being entered.
  assign timer_load_val = phase_ticks(state_d) - 6'd1;

  phase_timer #(
    .RESET_VAL(MAIN_GREEN_TICKS - 6'd1)
  ) u_phase_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (timer_done),
    .load_val (timer_load_val),
    .tick     (tick),
    .done     (timer_done)
  );

  always_comb begin
    state_d = state_q;
    if (timer_done) begin
      case (state_q)
        MAIN_GREEN:  state_d = MAIN_YELLOW;
        MAIN_YELLOW: state_d = ALL_RED_1;
        ALL_RED_1:   state_d = ped_pending_q ? PED_WALK : SIDE_GREEN;
        PED_WALK:    state_d = ALL_RED_2;
        ALL_RED_2:   state_d = SIDE_GREEN;
        SIDE_GREEN:  state_d = SIDE_YELLOW;
        SIDE_YELLOW: state_d = ALL_RED_3;
        ALL_RED_3:   state_d = MAIN_GREEN;
        default:     state_d = MAIN_GREEN;
      endcase
    end
  end

  // Entering the walk phase serves the request and wins over a same-cycle press.
  always_comb begin
    ped_pending_d = ped_pending_q;
    if (ped_req && (state_q != PED_WALK)) begin
      ped_pending_d = 1'b1;
    end
    if ((state_d == PED_WALK) && (state_q != PED_WALK)) begin
      ped_pending_d = 1'b0;
    end
  end

  always_comb begin
    cycle_cnt_d = cycle_cnt_q;
    if (tick) begin
      if (timer_done && (state_q == ALL_RED_3)) begin
        cycle_cnt_d = 6'd0;
      end else begin
        cycle_cnt_d = cycle_cnt_q + 6'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= MAIN_GREEN;
      ped_pending_q <= 1'b0;
      cycle_cnt_q   <= 6'd0;
    end else begin
      state_q       <= state_d;
      ped_pending_q <= ped_pending_d;
      cycle_cnt_q   <= cycle_cnt_d;
    end
  end

  always_comb begin
    main_light = RED;
    side_light = RED;
    walk       = 1'b0;
    case (state_q)
      MAIN_GREEN:  main_light = GRN;
      MAIN_YELLOW: main_light = YEL;
      SIDE_GREEN:  side_light = GRN;
      SIDE_YELLOW: side_light = YEL;
      PED_WALK:    walk       = 1'b1;
      default:     walk       = 1'b0;
    endcase
  end

  assign ped_pending = ped_pending_q;
  assign cycle_cnt   = cycle_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_traffic_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_traffic_sequencer
// Brief    : Scoreboard bench; a phase-list model predicts outputs per clock.
// Revision : 1.0 - initial release
// ============================================================================
module tb_traffic_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tick = 1'b0;
  logic       ped_req = 1'b0;
  logic [2:0] main_light;
  logic [2:0] side_light;
  logic       walk;
  logic       ped_pending;
  logic [5:0] cycle_cnt;

  traffic_sequencer dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .tick        (tick),
    .ped_req     (ped_req),
    .main_light  (main_light),
    .side_light  (side_light),
    .walk        (walk),
    .ped_pending (ped_pending),
    .cycle_cnt   (cycle_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] main_l;
    logic [2:0] side_l;
    logic       walk_l;
    logic       pend;
    logic [5:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  // Phase list: 0 MG,1 MY,2 AR1,3 WALK,4 AR2,5 SG,6 SY,7 AR3
  int         dur   [8] = '{15, 2, 2, 6, 2, 8, 2, 1};
  logic [2:0] m_tab [8] = '{3'b001, 3'b010, 3'b100, 3'b100, 3'b100, 3'b100, 3'b100, 3'b100};
  logic [2:0] s_tab [8] = '{3'b100, 3'b100, 3'b100, 3'b100, 3'b100, 3'b001, 3'b010, 3'b100};

  int m_ph = 0;
  int m_el = 0;
  int m_cnt = 0;
  bit m_pend = 1'b0;

  task automatic model_step(input bit r, input bit t, input bit p);
    bit new_pend;
    int nxt;
    if (!r) begin
      m_ph = 0; m_el = 0; m_cnt = 0; m_pend = 1'b0;
    end else begin
      new_pend = m_pend;
      if (p && m_ph != 3) new_pend = 1'b1;
      if (t) begin
        m_el++;
        m_cnt++;
        if (m_el == dur[m_ph]) begin
          if (m_ph == 2) nxt = m_pend ? 3 : 5;
          else nxt = (m_ph + 1) % 8;
          if (nxt == 0) m_cnt = 0;
          if (nxt == 3) new_pend = 1'b0;
          m_ph = nxt;
          m_el = 0;
        end
      end
      m_pend = new_pend;
    end
  endtask

  task automatic step(input bit r, input bit t, input bit p);
    exp_t e;
    @(negedge clk);
    rst_n = r; tick = t; ped_req = p;
    model_step(r, t, p);
    e.main_l = m_tab[m_ph];
    e.side_l = s_tab[m_ph];
    e.walk_l = (m_ph == 3);
    e.pend   = m_pend;
    e.cnt    = m_cnt[5:0];
    exp_q.push_back(e);
  endtask

  task automatic chk(input string name, input logic [5:0] act, input logic [5:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d at t=%0t", name, act, req, $time);
    end
  endtask

  // Monitor: pops one prediction per clock and also checks the safety rules.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("main_light", {3'b0, main_light}, {3'b0, e.main_l});
        chk("side_light", {3'b0, side_light}, {3'b0, e.side_l});
        chk("walk", {5'b0, walk}, {5'b0, e.walk_l});
        chk("ped_pending", {5'b0, ped_pending}, {5'b0, e.pend});
        chk("cycle_cnt", cycle_cnt, e.cnt);
        chk("both_roads_open", {5'b0, (main_light !== 3'b100) && (side_light !== 3'b100)}, 6'd0);
        chk("walk_not_all_red", {5'b0, walk && ((main_light !== 3'b100) || (side_light !== 3'b100))}, 6'd0);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    bit sent;
    int guard;

    // Plain cycle, tick every clock, no pedestrians.
    step(0, 1, 1); step(0, 0, 0);
    for (int i = 0; i < 32; i++) step(1, 1, 0);

    // Single press at cycle_cnt=3.
    step(0, 0, 0);
    sent = 1'b0;
    for (int i = 0; i < 42; i++) begin
      if (!sent && m_cnt == 3) begin
        step(1, 1, 1);
        sent = 1'b1;
      end else begin
        step(1, 1, 0);
      end
    end

    // Button held through a whole cycle.
    step(0, 0, 0);
    for (int i = 0; i < 42; i++) step(1, 1, 1);

    // Slow timebase with random presses.
    step(0, 0, 0);
    for (int i = 0; i < 170; i++) step(1, (i % 4) == 3, $urandom_range(0, 19) == 0);

    // Reset during the walk phase with two ticks left on its timer.
    step(0, 0, 0);
    guard = 0;
    while (!(m_ph == 3 && m_el == 3) && guard < 200) begin
      step(1, 1, 1);
      guard++;
    end
    chk("reach_walk_timer2", {5'b0, guard >= 200}, 6'd0);
    step(0, 1, 1);
    for (int i = 0; i < 10; i++) step(1, 1, 0);

    // Random soak including occasional resets.
    for (int i = 0; i < 2000; i++)
      step($urandom_range(0, 299) != 0, $urandom_range(0, 2) == 0, $urandom_range(0, 15) == 0);

    repeat (3) @(posedge clk);
    #3;
    chk("queue_drain", exp_q.size() > 63 ? 6'd63 : 6'(exp_q.size()), 6'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
